// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory port between I-cache line refills and D-cache single-word accesses.
// Optional macro ARB_ROUND_ROBIN_EN: on a simultaneous request the side not granted last wins.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned BEAT_W   = $clog2(BURST_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic [BEAT_W-1:0] i_beat,
  output logic              i_done,
  input  logic              d_req,
  input  logic [STRB_W-1:0] d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic [STRB_W-1:0] m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam int unsigned OFF_W = BEAT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_I_BURST  = 2'd1,
    S_D_ACCESS = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_pick_d;
  logic                w_i_act;
  logic                w_d_act;
  logic                w_last_beat;
  logic [BEAT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_addr;
  logic [STRB_W-1:0]   r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_d;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_unused_bits;

  assign w_unused_bits = ^{i_addr[OFF_W-1:0], d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_i;

  // D wins a collision only if I was granted most recently
  assign w_pick_d = d_req && (!i_req || r_last_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_i <= 1'b1;
    end else if (w_grant_d) begin
      r_last_i <= 1'b0;
    end else if (w_grant_i) begin
      r_last_i <= 1'b1;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  assign w_i_act     = (r_state == S_I_BURST);
  assign w_d_act     = (r_state == S_D_ACCESS);
  assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_i   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = S_D_ACCESS;
          w_grant_d   = 1'b1;
        end else if (i_req) begin
          w_state_nxt = S_I_BURST;
          w_grant_i   = 1'b1;
        end
      end
      S_I_BURST: begin
        if (m_ready && w_last_beat) begin
          w_state_nxt = S_RESP;
        end
      end
      S_D_ACCESS: begin
        if (m_ready) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Winner's request is captured on the grant edge; later requester changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_we    <= '0;
      r_wdata <= '0;
      r_is_d  <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
      r_we    <= d_we;
      r_wdata <= d_wdata;
      r_is_d  <= 1'b1;
    end else if (w_grant_i) begin
      r_addr  <= {i_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      r_we    <= '0;
      r_wdata <= '0;
      r_is_d  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (w_i_act && m_ready) begin
      r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_rdata <= '0;
    end else if (w_d_act && m_ready && (r_we == '0)) begin
      r_d_rdata <= m_rdata;
    end
  end

  // Memory side is driven only while a transaction is active, so reset drops it at once
  assign m_req    = w_i_act || w_d_act;
  assign m_addr   = w_i_act ? (r_addr + (ADDR_W'(r_beat) << 2)) :
                    w_d_act ? r_addr : '0;
  assign m_we     = w_d_act ? r_we : '0;
  assign m_wdata  = w_d_act ? r_wdata : '0;

  assign i_rvalid = w_i_act && m_ready;
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign i_beat   = r_beat;
  assign i_done   = (r_state == S_RESP) && !r_is_d;
  assign d_done   = (r_state == S_RESP) && r_is_d;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: an expected-beat queue is filled when a request is
// driven and drained as the bench's memory responder completes each beat.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic [1:0]  i_beat;
  logic        i_done;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req;
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  beat;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    lat;

  mem_bus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .i_beat   (i_beat),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_data_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic push_i(input logic [31:0] base);
    for (int b = 0; b < 4; b++) sb.push_back('{addr: base + 32'(4 * b), beat: 2'(b)});
  endtask

  task automatic wait_mreq(output int n);
    n = 0;
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("m_req_seen", 64'(m_req), 64'd1);
  endtask

  // Completes one beat after 'gap' idle cycles; returns at the following negedge+1
  task automatic serve_beat(input int gap, input logic [31:0] data, input bit is_i);
    beat_t e;
    repeat (gap) begin
      @(negedge clk); #1;
      chk("rvalid_while_waiting", 64'(i_rvalid), 64'd0);
    end
    m_ready = 1'b1;
    m_rdata = data;
    #1;
    e = (sb.size() > 0) ? sb.pop_front() : '1;
    chk("m_addr", 64'(m_addr), 64'(e.addr));
    if (is_i) begin
      chk("i_rvalid", 64'(i_rvalid), 64'd1);
      chk("i_rdata", 64'(i_rdata), 64'(data));
      chk("i_beat", 64'(i_beat), 64'(e.beat));
      chk("m_we_refill", 64'(m_we), 64'd0);
    end else begin
      chk("i_rvalid_on_d", 64'(i_rvalid), 64'd0);
    end
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = '0;
    #1;
  endtask

  task automatic serve_d(input int gap, input logic [31:0] data, input logic [3:0] we,
                         input logic [31:0] wdata, input bit drop, input logic [31:0] exp_rd,
                         output int n);
    wait_mreq(n);
    chk("m_we_d", 64'(m_we), 64'(we));
    chk("m_wdata_d", 64'(m_wdata), 64'(wdata));
    serve_beat(gap, data, 1'b0);
    chk("d_done", 64'(d_done), 64'd1);
    chk("i_done_on_d", 64'(i_done), 64'd0);
    chk("d_rdata", 64'(d_rdata), 64'(exp_rd));
    if (drop) d_req = 1'b0;
  endtask

  task automatic serve_i(input logic [31:0] base, output int n);
    wait_mreq(n);
    for (int b = 0; b < 4; b++) begin
      serve_beat(b % 3, i_data_of(base + 32'(4 * b)), 1'b1);
      if (b < 3) chk("i_done_early", 64'(i_done), 64'd0);
    end
    chk("i_done", 64'(i_done), 64'd1);
    chk("d_done_on_i", 64'(d_done), 64'd0);
    chk("m_req_resp", 64'(m_req), 64'd0);
    chk("i_beat_wrap", 64'(i_beat), 64'd0);
    i_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_req", 64'(m_req), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    chk("rst_i_done", 64'(i_done), 64'd0);
    chk("rst_d_done", 64'(d_done), 64'd0);
    chk("rst_d_rdata", 64'(d_rdata), 64'd0);
    chk("rst_i_beat", 64'(i_beat), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // D load
    @(negedge clk);
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h104;
    sb.push_back('{addr: 32'h104, beat: 2'd0});
    #1;
    chk("grant_latency_pre", 64'(m_req), 64'd0);
    serve_d(3, 32'hDEADBEEF, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, lat);
    chk("d_load_latency", 64'(lat), 64'd1);
    @(negedge clk); #1;
    chk("d_done_pulse_end", 64'(d_done), 64'd0);
    chk("idle_m_req", 64'(m_req), 64'd0);

    // D byte store leaves d_rdata alone
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b0001; d_addr = 32'h20; d_wdata = 32'hAA;
    sb.push_back('{addr: 32'h20, beat: 2'd0});
    #1;
    serve_d(1, 32'h1234_5678, 4'b0001, 32'hAA, 1'b1, 32'hDEADBEEF, lat);
    @(negedge clk);

    // Unaligned D load is word-aligned
    @(negedge clk);
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h10B;
    sb.push_back('{addr: 32'h108, beat: 2'd0});
    #1;
    serve_d(0, 32'hCAFEF00D, 4'h0, 32'hAA, 1'b1, 32'hCAFEF00D, lat);
    @(negedge clk);

    // I refill of an unaligned miss address
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1234;
    push_i(32'h1230);
    #1;
    serve_i(32'h1230, lat);
    chk("i_latency", 64'(lat), 64'd1);
    @(negedge clk); #1;
    chk("i_done_pulse_end", 64'(i_done), 64'd0);

    // Collision: D first; D stays asserted to force a repeat collision
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h2000;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h300;
    sb.push_back('{addr: 32'h300, beat: 2'd0});
    #1;
    serve_d(2, 32'h1111_1111, 4'h0, 32'hAA, 1'b0, 32'h1111_1111, lat);
`ifdef ARB_ROUND_ROBIN_EN
    push_i(32'h2000);
    @(negedge clk); #1;
    chk("idle_after_d", 64'(m_req), 64'd0);
    serve_i(32'h2000, lat);
    chk("rr_i_latency", 64'(lat), 64'd1);
    sb.push_back('{addr: 32'h300, beat: 2'd0});
    @(negedge clk); #1;
    serve_d(0, 32'h2222_2222, 4'h0, 32'hAA, 1'b1, 32'h2222_2222, lat);
    chk("rr_d_latency", 64'(lat), 64'd1);
`else
    sb.push_back('{addr: 32'h300, beat: 2'd0});
    @(negedge clk); #1;
    chk("idle_after_d", 64'(m_req), 64'd0);
    serve_d(0, 32'h2222_2222, 4'h0, 32'hAA, 1'b1, 32'h2222_2222, lat);
    chk("prio_d_latency", 64'(lat), 64'd1);
    push_i(32'h2000);
    @(negedge clk); #1;
    chk("i_waits_idle", 64'(m_req), 64'd0);
    serve_i(32'h2000, lat);
    chk("i_after_d_latency", 64'(lat), 64'd1);
`endif
    @(negedge clk);

    // Reset in the middle of a refill
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4008;
    push_i(32'h4000);
    #1;
    wait_mreq(lat);
    serve_beat(0, i_data_of(32'h4000), 1'b1);
    serve_beat(1, i_data_of(32'h4004), 1'b1);
    m_ready = 1'b1;
    m_rdata = 32'h5555_5555;
    #1;
    chk("pre_reset_rvalid", 64'(i_rvalid), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_m_req", 64'(m_req), 64'd0);
    chk("async_rst_rvalid", 64'(i_rvalid), 64'd0);
    chk("async_rst_i_done", 64'(i_done), 64'd0);
    chk("async_rst_i_beat", 64'(i_beat), 64'd0);
    chk("async_rst_d_rdata", 64'(d_rdata), 64'd0);
    m_ready = 1'b0;
    m_rdata = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    push_i(32'h4000);
    #1;
    serve_i(32'h4000, lat);
    chk("restart_latency", 64'(lat), 64'd1);
    @(negedge clk);

    // Stray m_ready while idle
    @(negedge clk);
    m_ready = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    #1;
    chk("stray_rvalid", 64'(i_rvalid), 64'd0);
    chk("stray_rdata", 64'(i_rdata), 64'd0);
    @(negedge clk);
    m_ready = 1'b0;
    m_rdata = '0;
    #1;
    chk("stray_i_done", 64'(i_done), 64'd0);
    chk("stray_d_done", 64'(d_done), 64'd0);
    chk("stray_m_req", 64'(m_req), 64'd0);
    chk("stray_d_rdata", 64'(d_rdata), 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
